serial_adder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands DIGIT bits per clock, propagating carry through a registered carry flop between slices. It is the sequential successor to the gate-level half/full adder cells. It trades latency for area in datapaths where a full-width ripple adder is too large. The block sits behind a simple start/done handshake and holds its last result until the next operation completes.

---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds WIDTH-bit operands DIGIT bits per clock through a registered carry.
// Latency K+1 edges from accept to done (K = WIDTH/DIGIT). Start is ignored during RUN; result holds until next completion.
// Optional subtract mode when ADD_SUB_EN is defined (adds a sub input).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             accept;

    always_comb begin
`ifdef ADD_SUB_EN
        // Subtraction as a + ~b + 1; carry=1 then means no borrow.
        b_in   = sub ? ~b : b;
        cin_in = sub ? 1'b1 : cin;
`else
        b_in   = b;
        cin_in = cin;
`endif
    end

    always_comb begin
        slice  = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, cy_q};
        s_ext  = WIDTH'(slice[DIGIT-1:0]);
        accept = start && (state_q == IDLE || state_q == DONE);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        psum_d  = psum_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            RUN: begin
                // Slices enter from the MSB side so after K shifts the LSB slice sits at bit 0.
                psum_d = (psum_q >> DIGIT) | (s_ext << (WIDTH - DIGIT));
                cy_d   = slice[DIGIT];
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    sum_d   = psum_d;
                    carry_d = slice[DIGIT];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b_in;
            cy_d    = cin_in;
            psum_d  = '0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            psum_q  <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            psum_q  <= psum_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances with DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      start_v = '0;
    logic [2:0]      cin_v = '0;
    logic [2:0]      sub_v = '0;
    logic [2:0][7:0] a_v = '0;
    logic [2:0][7:0] b_v = '0;
    logic [2:0]      busy_v;
    logic [2:0]      done_v;
    logic [2:0]      carry_v;
    logic [2:0][7:0] sum_v;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
`ifdef ADD_SUB_EN
        .sub(sub_v[0]),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .carry(carry_v[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
`ifdef ADD_SUB_EN
        .sub(sub_v[1]),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .carry(carry_v[1])
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
`ifdef ADD_SUB_EN
        .sub(sub_v[2]),
`endif
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .carry(carry_v[2])
    );

    // Called #1 after a rising edge; returns #1 after the accepting edge E0.
    task automatic launch(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
        a_v[idx]     = a;
        b_v[idx]     = b;
        cin_v[idx]   = cin;
        sub_v[idx]   = sub;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    // lat = edges after E0 until done is seen; bc = cycles with busy high.
    task automatic wait_done(input int idx, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (done_v[idx] !== 1'b1 && lat < 40) begin
            if (busy_v[idx] === 1'b1) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (busy_v[0] !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_v[0]); else passed++;
        checks++; if (done_v[0] !== 1'b0) $display("FAIL reset_done got %b want 0", done_v[0]); else passed++;
        checks++; if (sum_v[0] !== 8'h00) $display("FAIL reset_sum got %h want 00", sum_v[0]); else passed++;
        checks++; if (carry_v[0] !== 1'b0) $display("FAIL reset_carry got %b want 0", carry_v[0]); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int lat, bc;
        launch(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        checks++; if (busy_v[0] !== 1'b1) $display("FAIL add_busy_e0 got %b want 1", busy_v[0]); else passed++;
        wait_done(0, lat, bc);
        checks++; if (lat != 8) $display("FAIL add_latency got %0d want 8", lat); else passed++;
        checks++; if (bc != 8) $display("FAIL add_busy_cycles got %0d want 8", bc); else passed++;
        checks++; if (busy_v[0] !== 1'b0) $display("FAIL add_busy_at_done got %b want 0", busy_v[0]); else passed++;
        checks++; if (sum_v[0] !== 8'h96) $display("FAIL add_sum got %h want 96", sum_v[0]); else passed++;
        checks++; if (carry_v[0] !== 1'b0) $display("FAIL add_carry got %b want 0", carry_v[0]); else passed++;
        @(posedge clk);
        #1;
        checks++; if (done_v[0] !== 1'b0) $display("FAIL add_done_pulse got %b want 0", done_v[0]); else passed++;
        checks++; if (sum_v[0] !== 8'h96) $display("FAIL add_sum_hold got %h want 96", sum_v[0]); else passed++;
    endtask

    task automatic test_wrap();
        int lat, bc;
        launch(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(0, lat, bc);
        checks++; if (sum_v[0] !== 8'h00) $display("FAIL wrap1_sum got %h want 00", sum_v[0]); else passed++;
        checks++; if (carry_v[0] !== 1'b1) $display("FAIL wrap1_carry got %b want 1", carry_v[0]); else passed++;
        @(posedge clk);
        #1;
        launch(0, 8'hFF, 8'h00, 1'b1, 1'b0);
        wait_done(0, lat, bc);
        checks++; if (sum_v[0] !== 8'h00) $display("FAIL wrap2_sum got %h want 00", sum_v[0]); else passed++;
        checks++; if (carry_v[0] !== 1'b1) $display("FAIL wrap2_carry got %b want 1", carry_v[0]); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(0, 8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        // Result register must hold the previous result during RUN.
        checks++; if (sum_v[0] !== 8'h00 || carry_v[0] !== 1'b1)
            $display("FAIL run_hold got %h/%b want 00/1", sum_v[0], carry_v[0]); else passed++;
        launch(0, 8'h10, 8'h10, 1'b0, 1'b0);
        wait_done(0, lat, bc);
        checks++; if (lat != 5) $display("FAIL ignore_latency got %0d want 5", lat); else passed++;
        checks++; if (sum_v[0] !== 8'h02) $display("FAIL ignore_sum got %h want 02", sum_v[0]); else passed++;
        launch(0, 8'h10, 8'h10, 1'b0, 1'b0);
        checks++; if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0)
            $display("FAIL b2b_accept got busy=%b done=%b want 1/0", busy_v[0], done_v[0]); else passed++;
        wait_done(0, lat, bc);
        checks++; if (lat != 8) $display("FAIL b2b_latency got %0d want 8", lat); else passed++;
        checks++; if (sum_v[0] !== 8'h20) $display("FAIL b2b_sum got %h want 20", sum_v[0]); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int saw_done;
        launch(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (busy_v[0] !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_v[0]); else passed++;
        checks++; if (done_v[0] !== 1'b0) $display("FAIL midrst_done got %b want 0", done_v[0]); else passed++;
        checks++; if (sum_v[0] !== 8'h00 || carry_v[0] !== 1'b0)
            $display("FAIL midrst_result got %h/%b want 00/0", sum_v[0], carry_v[0]); else passed++;
        #3;
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) saw_done++;
        end
        checks++; if (saw_done != 0) $display("FAIL midrst_no_done got %0d active cycles want 0", saw_done); else passed++;
    endtask

    task automatic test_digits();
        int lat, bc;
        launch(1, 8'h9C, 8'h87, 1'b0, 1'b0);
        wait_done(1, lat, bc);
        checks++; if (lat != 2) $display("FAIL d4_latency got %0d want 2", lat); else passed++;
        checks++; if (sum_v[1] !== 8'h23 || carry_v[1] !== 1'b1)
            $display("FAIL d4_result got %h/%b want 23/1", sum_v[1], carry_v[1]); else passed++;
        @(posedge clk);
        #1;
        launch(2, 8'h9C, 8'h87, 1'b0, 1'b0);
        wait_done(2, lat, bc);
        checks++; if (lat != 1) $display("FAIL d8_latency got %0d want 1", lat); else passed++;
        checks++; if (sum_v[2] !== 8'h23 || carry_v[2] !== 1'b1)
            $display("FAIL d8_result got %h/%b want 23/1", sum_v[2], carry_v[2]); else passed++;
        @(posedge clk);
        #1;
        launch(1, 8'hA5, 8'h5A, 1'b1, 1'b0);
        wait_done(1, lat, bc);
        checks++; if (sum_v[1] !== 8'h00 || carry_v[1] !== 1'b1)
            $display("FAIL d4_cin_result got %h/%b want 00/1", sum_v[1], carry_v[1]); else passed++;
        @(posedge clk);
        #1;
    endtask

`ifdef ADD_SUB_EN
    task automatic test_sub();
        int lat, bc;
        launch(0, 8'h10, 8'h01, 1'b0, 1'b1);
        wait_done(0, lat, bc);
        checks++; if (sum_v[0] !== 8'h0F || carry_v[0] !== 1'b1)
            $display("FAIL sub1_result got %h/%b want 0F/1", sum_v[0], carry_v[0]); else passed++;
        @(posedge clk);
        #1;
        launch(0, 8'h00, 8'h01, 1'b1, 1'b1);
        wait_done(0, lat, bc);
        checks++; if (sum_v[0] !== 8'hFF || carry_v[0] !== 1'b0)
            $display("FAIL sub2_result got %h/%b want FF/0", sum_v[0], carry_v[0]); else passed++;
        @(posedge clk);
        #1;
        launch(1, 8'h10, 8'h01, 1'b0, 1'b1);
        wait_done(1, lat, bc);
        checks++; if (sum_v[1] !== 8'h0F || carry_v[1] !== 1'b1)
            $display("FAIL sub_d4_result got %h/%b want 0F/1", sum_v[1], carry_v[1]); else passed++;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_digits();
`ifdef ADD_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
